// File: rtl/instr_enc.sv
// MSP430 instruction encoder: packs one decoded instruction into machine words (instr, src ext, dst ext).
// Latency: first word valid the cycle after request acceptance; one cycle per word with word_ready high.
// Backpressure: req_ready only in IDLE; word_out/word_addr held while word_ready is low.
//
// Ports: clk/rst_n (async active-low); req_valid/req_ready plus request fields
//   (fmt, op, op2, jcond, joff, sa, da, as, ad, bw, src_ext, dst_ext);
//   addr_load/addr_in reload the byte address counter (IDLE only);
//   word_out/word_addr/word_valid/word_ready output stream; done/err one-cycle pulses.
// Optional feature: define INSTR_ENC_CG_EN to treat sa==3/as==01 as constant +1 (no source ext word).
module instr_enc #(
  parameter logic [15:0] BASE_ADDR = 16'hC000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  op,
  input  logic [2:0]  op2,
  input  logic [2:0]  jcond,
  input  logic [9:0]  joff,
  input  logic [3:0]  sa,
  input  logic [3:0]  da,
  input  logic [1:0]  as,
  input  logic        ad,
  input  logic        bw,
  input  logic [15:0] src_ext,
  input  logic [15:0] dst_ext,
  input  logic        addr_load,
  input  logic [15:0] addr_in,
  output logic [15:0] word_out,
  output logic [15:0] word_addr,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INSTR = 2'd1;
  localparam logic [1:0] S_SRC   = 2'd2;
  localparam logic [1:0] S_DST   = 2'd3;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic        need_src_q;
  logic        need_dst_q;

  logic        legal;
  logic        need_src;
  logic        need_dst;
  logic        idx_mode;
  logic [15:0] enc;

  assign req_ready  = (state == S_IDLE);
  assign word_valid = (state != S_IDLE);
  // The counter always points at the word currently offered (or the next one to be offered).
  assign word_addr  = cnt;

  always_comb begin
    legal    = 1'b1;
    enc      = 16'h0000;
    idx_mode = 1'b0;
    case (fmt)
      2'd0: legal = 1'b0;
      2'd1: begin
        legal = (op >= 4'd4);
        enc   = {op, sa, ad, bw, as, da};
      end
      2'd2: begin
        legal = (op2 != 3'd7);
        enc   = {6'b000100, op2, bw, as, sa};
      end
      default: enc = {3'b001, jcond, joff};
    endcase

`ifdef INSTR_ENC_CG_EN
    // r3 with as==01 is the constant generator (+1): no extension word.
    idx_mode = (as == 2'b01) && (sa != 4'd3);
`else
    idx_mode = (as == 2'b01);
`endif

    need_src = ((fmt == 2'd1) || (fmt == 2'd2)) &&
               (idx_mode || ((as == 2'b11) && (sa == 4'd0)));
    need_dst = (fmt == 2'd1) && ad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= BASE_ADDR;
      word_out   <= 16'h0000;
      src_q      <= 16'h0000;
      dst_q      <= 16'h0000;
      need_src_q <= 1'b0;
      need_dst_q <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load in the acceptance cycle sets the address of the first word.
          if (addr_load) cnt <= {addr_in[15:1], 1'b0};
          if (req_valid) begin
            if (legal) begin
              state      <= S_INSTR;
              word_out   <= enc;
              src_q      <= src_ext;
              dst_q      <= dst_ext;
              need_src_q <= need_src;
              need_dst_q <= need_dst;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_INSTR: begin
          if (word_ready) begin
            cnt <= cnt + 16'd2;
            if (need_src_q) begin
              state    <= S_SRC;
              word_out <= src_q;
            end else if (need_dst_q) begin
              state    <= S_DST;
              word_out <= dst_q;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        S_SRC: begin
          if (word_ready) begin
            cnt <= cnt + 16'd2;
            if (need_dst_q) begin
              state    <= S_DST;
              word_out <= dst_q;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          if (word_ready) begin
            cnt   <= cnt + 16'd2;
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc: hand-encoded MSP430 words, address tracking, stalls, wrap, reset abort.
// Inputs are driven and outputs sampled on the falling edge.
// Build with or without INSTR_ENC_CG_EN; the r3/as==01 case expects accordingly.
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  r_fmt = '0;
  logic [3:0]  r_op = '0;
  logic [2:0]  r_op2 = '0;
  logic [2:0]  r_jcond = '0;
  logic [9:0]  r_joff = '0;
  logic [3:0]  r_sa = '0;
  logic [3:0]  r_da = '0;
  logic [1:0]  r_as = '0;
  logic        r_ad = 1'b0;
  logic        r_bw = 1'b0;
  logic [15:0] r_src = '0;
  logic [15:0] r_dst = '0;
  logic        addr_load = 1'b0;
  logic [15:0] addr_in = '0;
  logic [15:0] word_out;
  logic [15:0] word_addr;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        done;
  logic        err;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] exp_addr = 16'hC000;

  instr_enc #(.BASE_ADDR(16'hC000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .fmt(r_fmt), .op(r_op), .op2(r_op2), .jcond(r_jcond), .joff(r_joff),
    .sa(r_sa), .da(r_da), .as(r_as), .ad(r_ad), .bw(r_bw),
    .src_ext(r_src), .dst_ext(r_dst),
    .addr_load(addr_load), .addr_in(addr_in),
    .word_out(word_out), .word_addr(word_addr), .word_valid(word_valid),
    .word_ready(word_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left on a falling edge; request accepted at the rising edge in between.
  task automatic do_req(input logic [1:0] f, input logic [3:0] o, input logic [2:0] o2,
                        input logic [2:0] jc, input logic [9:0] jo, input logic [3:0] s,
                        input logic [3:0] d, input logic [1:0] a_s, input logic a_d,
                        input logic b, input logic [15:0] se, input logic [15:0] de);
    r_fmt = f; r_op = o; r_op2 = o2; r_jcond = jc; r_joff = jo;
    r_sa = s; r_da = d; r_as = a_s; r_ad = a_d; r_bw = b; r_src = se; r_dst = de;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load_addr(input logic [15:0] a);
    addr_load = 1'b1;
    addr_in   = a;
    @(negedge clk);
    addr_load = 1'b0;
  endtask

  // Check the offered word, optionally stall, then accept it.
  task automatic get_word(input string tag, input logic [15:0] w, input int stall);
    int i = 0;
    while (!word_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_vld"}, word_valid, 1);
    chk({tag, "_dat"}, word_out, w);
    chk({tag, "_adr"}, word_addr, exp_addr);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, word_valid, 1);
      chk({tag, "_hold_dat"}, word_out, w);
      chk({tag, "_hold_adr"}, word_addr, exp_addr);
    end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    exp_addr = exp_addr + 16'd2;
  endtask

  task automatic finish_req(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idle_vld"}, word_valid, 0);
    chk({tag, "_next_adr"}, word_addr, exp_addr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_out", word_out, 16'h0000);
    chk("rst_word_addr", word_addr, 16'hC000);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MOV #0x1234,R5
    do_req(2'd1, 4'd4, 3'd0, 3'd0, 10'd0, 4'd0, 4'd5, 2'b11, 1'b0, 1'b0, 16'h1234, 16'h0);
    get_word("mov_i", 16'h4035, 0);
    get_word("mov_s", 16'h1234, 0);
    finish_req("mov");
    @(negedge clk);
    chk("mov_done_pulse", done, 0);

    // Reload with an odd address: bit 0 is dropped.
    load_addr(16'hC001);
    exp_addr = 16'hC000;
    chk("load_odd_adr", word_addr, 16'hC000);

    // ADD R4,6(R7), stalled dst word; an addr_load while busy must be ignored.
    do_req(2'd1, 4'd5, 3'd0, 3'd0, 10'd0, 4'd4, 4'd7, 2'b00, 1'b1, 1'b0, 16'h0, 16'h0006);
    get_word("add_i", 16'h5487, 0);
    addr_load = 1'b1;
    addr_in   = 16'h1234;
    get_word("add_d", 16'h0006, 3);
    addr_load = 1'b0;
    finish_req("add");

    // ADD #1,R5 via r3/as==01
    do_req(2'd1, 4'd5, 3'd0, 3'd0, 10'd0, 4'd3, 4'd5, 2'b01, 1'b0, 1'b0, 16'hBEEF, 16'h0);
    get_word("cg_i", 16'h5315, 0);
`ifndef INSTR_ENC_CG_EN
    get_word("cg_s", 16'hBEEF, 0);
`endif
    finish_req("cg");

    // JMP -2 with addr_load in the acceptance cycle, then PUSH R10 accepted in the done cycle.
    addr_load = 1'b1;
    addr_in   = 16'h8000;
    do_req(2'd3, 4'd0, 3'd0, 3'd7, 10'h3FE, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    addr_load = 1'b0;
    exp_addr  = 16'h8000;
    get_word("jmp_i", 16'h3FFE, 0);
    finish_req("jmp");
    do_req(2'd2, 4'd0, 3'd4, 3'd0, 10'd0, 4'd10, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    get_word("push_i", 16'h120A, 0);
    finish_req("push");

    // Illegal requests: fmt1/op3, fmt0, fmt2/op2==7
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: do_req(2'd1, 4'd3, 3'd0, 3'd0, 10'd0, 4'd4, 4'd5, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
        1: do_req(2'd0, 4'd4, 3'd0, 3'd0, 10'd0, 4'd4, 4'd5, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
        default: do_req(2'd2, 4'd0, 3'd7, 3'd0, 10'd0, 4'd4, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
      endcase
      chk($sformatf("ill%0d_err", t), err, 1);
      chk($sformatf("ill%0d_vld", t), word_valid, 0);
      chk($sformatf("ill%0d_adr", t), word_addr, exp_addr);
      chk($sformatf("ill%0d_rdy", t), req_ready, 1);
      @(negedge clk);
      chk($sformatf("ill%0d_err_pulse", t), err, 0);
      chk($sformatf("ill%0d_vld2", t), word_valid, 0);
    end

    // Address wrap
    load_addr(16'hFFFE);
    exp_addr = 16'hFFFE;
    do_req(2'd1, 4'd4, 3'd0, 3'd0, 10'd0, 4'd0, 4'd5, 2'b11, 1'b0, 1'b0, 16'h1234, 16'h0);
    get_word("wrap_i", 16'h4035, 0);
    get_word("wrap_s", 16'h1234, 0);
    finish_req("wrap");

    // Reset during the second word
    @(negedge clk);
    do_req(2'd1, 4'd4, 3'd0, 3'd0, 10'd0, 4'd0, 4'd5, 2'b11, 1'b0, 1'b0, 16'h1234, 16'h0);
    get_word("abort_i", 16'h4035, 0);
    chk("abort_second_vld", word_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_vld", word_valid, 0);
    chk("abort_adr", word_addr, 16'hC000);
    chk("abort_dat", word_out, 16'h0000);
    chk("abort_rdy", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_addr = 16'hC000;
    do_req(2'd3, 4'd0, 3'd0, 3'd7, 10'h3FE, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0);
    get_word("post_rst_i", 16'h3FFE, 0);
    finish_req("post_rst");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
